// File: rtl/fifo_np2_pkg.sv
// ============================================================================
// fifo_np2_pkg : shared widths, pointer wrap helper and scanline constant
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_np2_pkg;

  localparam int unsigned LINE_PIXELS = 240;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Depth need not be a power of two, so the wrap is explicit.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_np2_ram.sv
// ============================================================================
// fifo_np2_ram : simple dual-port RAM, write port A, registered read port B
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_np2_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 240,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read samples the pre-write word on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_np2.sv
// ============================================================================
// fifo_np2 : synchronous FIFO controller for arbitrary (non-2^n) depth
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_np2
  import fifo_np2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = LINE_PIXELS,
  parameter int unsigned AFULL_LEVEL = 224
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = lvl_width(DEPTH);

  localparam logic [LVL_W-1:0] c_full_lvl  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] c_afull_lvl = LVL_W'(AFULL_LEVEL);
  localparam logic [LVL_W-1:0] c_one       = LVL_W'(1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_pop_ok;
  logic             w_push_ok;

  // A full FIFO may still accept a push when a pop frees the slot this cycle.
  assign w_pop_ok  = rd_en & ~r_empty;
  assign w_push_ok = wr_en & (~r_full | w_pop_ok);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push_ok && !w_pop_ok) begin
      w_level_nxt = r_level + c_one;
    end else if (w_pop_ok && !w_push_ok) begin
      w_level_nxt = r_level - c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
      end
      if (w_pop_ok) begin
        r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
      end
      r_level     <= w_level_nxt;
      r_empty     <= (w_level_nxt == '0);
      r_full      <= (w_level_nxt == c_full_lvl);
      r_afull     <= (w_level_nxt >= c_afull_lvl);
      r_rd_valid  <= w_pop_ok;
      r_overflow  <= r_overflow  | (wr_en & ~w_push_ok);
      r_underflow <= r_underflow | (rd_en & ~w_pop_ok);
    end
  end

  fifo_np2_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_push_ok & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_re    (w_pop_ok & ~reset),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign full        = r_full;
  assign almost_full = r_afull;
  assign empty       = r_empty;
  assign level       = r_level;
  assign rd_valid    = r_rd_valid;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

`default_nettype wire
